rhd_axil_regs: RTL and testbench

RHD_AXIL_REGS -- requirements
Module: rhd_axil_regs

---
 rtl/rhd_axil_regs_if.sv | 73 +++++++
 rtl/rhd_axil_regs.sv | 251 +++++++++++++++++++++++++
 tb/tb_rhd_axil_regs.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rhd_axil_regs_if.sv
// -----------------------------------------------------------------------------
// rhd_axil_regs_if
// AXI4-Lite bus bundle for the rhd_axil_regs register block.
//
// Parameter:
//   ADDR_WIDTH  byte address width of the AW/AR channels
//
// Signals (names follow the s_axi_* slave naming of the block):
//   AW : s_axi_awaddr, s_axi_awprot, s_axi_awvalid -> / <- s_axi_awready
//   W  : s_axi_wdata, s_axi_wstrb, s_axi_wvalid    -> / <- s_axi_wready
//   B  : s_axi_bresp, s_axi_bvalid                 <- / -> s_axi_bready
//   AR : s_axi_araddr, s_axi_arprot, s_axi_arvalid -> / <- s_axi_arready
//   R  : s_axi_rdata, s_axi_rresp, s_axi_rvalid    <- / -> s_axi_rready
//
// Modports:
//   master  drives requests, receives responses
//   slave   receives requests, drives responses
// -----------------------------------------------------------------------------
interface rhd_axil_regs_if #(
  parameter int ADDR_WIDTH = 5
);

  logic [ADDR_WIDTH-1:0] s_axi_awaddr;
  logic [2:0]            s_axi_awprot;
  logic                  s_axi_awvalid;
  logic                  s_axi_awready;

  logic [31:0]           s_axi_wdata;
  logic [3:0]            s_axi_wstrb;
  logic                  s_axi_wvalid;
  logic                  s_axi_wready;

  logic [1:0]            s_axi_bresp;
  logic                  s_axi_bvalid;
  logic                  s_axi_bready;

  logic [ADDR_WIDTH-1:0] s_axi_araddr;
  logic [2:0]            s_axi_arprot;
  logic                  s_axi_arvalid;
  logic                  s_axi_arready;

  logic [31:0]           s_axi_rdata;
  logic [1:0]            s_axi_rresp;
  logic                  s_axi_rvalid;
  logic                  s_axi_rready;

  modport master (
    output s_axi_awaddr, s_axi_awprot, s_axi_awvalid,
    input  s_axi_awready,
    output s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
    input  s_axi_wready,
    input  s_axi_bresp, s_axi_bvalid,
    output s_axi_bready,
    output s_axi_araddr, s_axi_arprot, s_axi_arvalid,
    input  s_axi_arready,
    input  s_axi_rdata, s_axi_rresp, s_axi_rvalid,
    output s_axi_rready
  );

  modport slave (
    input  s_axi_awaddr, s_axi_awprot, s_axi_awvalid,
    output s_axi_awready,
    input  s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
    output s_axi_wready,
    output s_axi_bresp, s_axi_bvalid,
    input  s_axi_bready,
    input  s_axi_araddr, s_axi_arprot, s_axi_arvalid,
    output s_axi_arready,
    output s_axi_rdata, s_axi_rresp, s_axi_rvalid,
    input  s_axi_rready
  );

endinterface

// File: rtl/rhd_axil_regs.sv
// -----------------------------------------------------------------------------
// rhd_axil_regs
// AXI4-Lite control/status register block for the RHD core.
//
// Register map (word index = addr[ADDR_WIDTH-1:2], addr[1:0] ignored):
//   0x00 CTRL       bit0 INIT (write-1 pulse, reads 0), bit5 LOOPBACK (RW)
//   0x04 MISO_DELAY 32-bit RW
//   0x08 PKT_LEN    bits[15:0] RW, a committed 0 is stored as 1
//   0x0C STATUS     bit0 core_busy (live), bit1 OVF (sticky, write-1-clear)
//   0x10-0x1C       unmapped: SLVERR, reads 0, writes ignored
//
// Ports:
//   rhd_aclk      clock, rising edge
//   rhd_areset    asynchronous active-high reset
//   axi           AXI4-Lite slave (rhd_axil_regs_if.slave)
//   init_pulse    one-cycle pulse after a CTRL write with INIT=1
//   loopback_en   CTRL.LOOPBACK
//   miso_delay    MISO_DELAY register
//   pkt_len       PKT_LEN register
//   core_busy     live busy status from the core
//   overflow_evt  single-cycle overflow event from the core
// -----------------------------------------------------------------------------
module rhd_axil_regs #(
  parameter int          ADDR_WIDTH  = 5,
  parameter logic [15:0] PKT_LEN_RST = 16'd8
) (
  input  logic                  rhd_aclk,
  input  logic                  rhd_areset,
  rhd_axil_regs_if.slave        axi,
  output logic                  init_pulse,
  output logic                  loopback_en,
  output logic [31:0]           miso_delay,
  output logic [15:0]           pkt_len,
  input  logic                  core_busy,
  input  logic                  overflow_evt
);

  localparam int IDX_W = ADDR_WIDTH - 2;

  localparam logic [IDX_W-1:0] IDX_CTRL   = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_MISO   = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_PKT    = IDX_W'(2);
  localparam logic [IDX_W-1:0] IDX_STATUS = IDX_W'(3);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Handshake semantics on every channel: a beat transfers on a rising edge
  // where both valid and ready are high. The source holds valid and payload
  // stable until that edge; this block never withdraws bvalid/rvalid or
  // changes bresp/rdata/rresp before the beat is taken.

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                  r_rst_done;   // keeps readies low until first edge after reset
  logic                  r_aw_held;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic                  r_w_held;
  logic [31:0]           r_wdata;
  logic [3:0]            r_wstrb;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic                  r_rvalid;
  logic [1:0]            r_rresp;
  logic [31:0]           r_rdata;
  logic                  r_init_pulse;
  logic                  r_loopback;
  logic [31:0]           r_miso_delay;
  logic [15:0]           r_pkt_len;
  logic                  r_ovf;

  // ---------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------
  logic                  w_awready;
  logic                  w_wready;
  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_commit;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [31:0]           w_wdata;
  logic [3:0]            w_wstrb;
  logic [IDX_W-1:0]      w_widx;
  logic                  w_wmapped;
  logic                  w_wr_ctrl;
  logic                  w_wr_miso;
  logic                  w_wr_pkt;
  logic                  w_ovf_clr;
  logic [31:0]           w_miso_next;
  logic [15:0]           w_pkt_merged;
  logic [15:0]           w_pkt_next;

  assign w_awready = r_rst_done & ~r_aw_held & ~r_bvalid;
  assign w_wready  = r_rst_done & ~r_w_held  & ~r_bvalid;
  assign w_aw_hs   = axi.s_axi_awvalid & w_awready;
  assign w_w_hs    = axi.s_axi_wvalid  & w_wready;

  // Commit as soon as both halves are available: either already held or
  // arriving on this very edge. Covers AW-first, W-first and same-cycle.
  assign w_commit = (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs);

  assign w_waddr = r_aw_held ? r_awaddr : axi.s_axi_awaddr;
  assign w_wdata = r_w_held  ? r_wdata  : axi.s_axi_wdata;
  assign w_wstrb = r_w_held  ? r_wstrb  : axi.s_axi_wstrb;

  assign w_widx    = w_waddr[ADDR_WIDTH-1:2];
  assign w_wmapped = (32'(w_widx) < 32'd4);

  assign w_wr_ctrl = w_commit & (w_widx == IDX_CTRL);
  assign w_wr_miso = w_commit & (w_widx == IDX_MISO);
  assign w_wr_pkt  = w_commit & (w_widx == IDX_PKT);
  assign w_ovf_clr = w_commit & (w_widx == IDX_STATUS) & w_wstrb[0] & w_wdata[1];

  always_comb begin
    w_miso_next = r_miso_delay;
    for (int b = 0; b < 4; b++) begin
      if (w_wstrb[b]) w_miso_next[8*b +: 8] = w_wdata[8*b +: 8];
    end
  end

  assign w_pkt_merged = {w_wstrb[1] ? w_wdata[15:8] : r_pkt_len[15:8],
                         w_wstrb[0] ? w_wdata[7:0]  : r_pkt_len[7:0]};
  // A zero packet length is meaningless to the core; clamp it to 1.
  assign w_pkt_next   = (w_pkt_merged == 16'd0) ? 16'd1 : w_pkt_merged;

  always_ff @(posedge rhd_aclk or posedge rhd_areset) begin
    if (rhd_areset) begin
      r_rst_done <= 1'b0;
      r_aw_held  <= 1'b0;
      r_awaddr   <= '0;
      r_w_held   <= 1'b0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
    end else begin
      r_rst_done <= 1'b1;

      if (w_commit) begin
        r_aw_held <= 1'b0;
      end else if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_awaddr  <= axi.s_axi_awaddr;
      end

      if (w_commit) begin
        r_w_held <= 1'b0;
      end else if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_wdata  <= axi.s_axi_wdata;
        r_wstrb  <= axi.s_axi_wstrb;
      end

      if (w_commit) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_wmapped ? RESP_OKAY : RESP_SLVERR;
      end else if (r_bvalid && axi.s_axi_bready) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  always_ff @(posedge rhd_aclk or posedge rhd_areset) begin
    if (rhd_areset) begin
      r_init_pulse <= 1'b0;
      r_loopback   <= 1'b0;
      r_miso_delay <= '0;
      r_pkt_len    <= PKT_LEN_RST;
      r_ovf        <= 1'b0;
    end else begin
      r_init_pulse <= w_wr_ctrl & w_wstrb[0] & w_wdata[0];

      if (w_wr_ctrl && w_wstrb[0]) r_loopback <= w_wdata[5];
      if (w_wr_miso)               r_miso_delay <= w_miso_next;
      if (w_wr_pkt && (w_wstrb[1:0] != 2'b00)) r_pkt_len <= w_pkt_next;

      // A new event on the clearing edge keeps the flag set.
      r_ovf <= overflow_evt | (r_ovf & ~w_ovf_clr);
    end
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  logic             w_arready;
  logic             w_ar_hs;
  logic [IDX_W-1:0] w_ridx;
  logic             w_rmapped;
  logic [31:0]      w_rdata_mux;

  assign w_arready = r_rst_done & ~r_rvalid;
  assign w_ar_hs   = axi.s_axi_arvalid & w_arready;
  assign w_ridx    = axi.s_axi_araddr[ADDR_WIDTH-1:2];
  assign w_rmapped = (32'(w_ridx) < 32'd4);

  // Reads sample the current register values, so a read landing on a
  // write's commit edge returns the pre-write contents.
  always_comb begin
    w_rdata_mux = 32'd0;
    case (w_ridx)
      IDX_CTRL:   w_rdata_mux = {26'd0, r_loopback, 5'd0};
      IDX_MISO:   w_rdata_mux = r_miso_delay;
      IDX_PKT:    w_rdata_mux = {16'd0, r_pkt_len};
      IDX_STATUS: w_rdata_mux = {30'd0, r_ovf, core_busy};
      default:    w_rdata_mux = 32'd0;
    endcase
  end

  always_ff @(posedge rhd_aclk or posedge rhd_areset) begin
    if (rhd_areset) begin
      r_rvalid <= 1'b0;
      r_rresp  <= RESP_OKAY;
      r_rdata  <= '0;
    end else begin
      if (w_ar_hs) begin
        r_rvalid <= 1'b1;
        r_rresp  <= w_rmapped ? RESP_OKAY : RESP_SLVERR;
        r_rdata  <= w_rdata_mux;
      end else if (r_rvalid && axi.s_axi_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign axi.s_axi_awready = w_awready;
  assign axi.s_axi_wready  = w_wready;
  assign axi.s_axi_bvalid  = r_bvalid;
  assign axi.s_axi_bresp   = r_bresp;
  assign axi.s_axi_arready = w_arready;
  assign axi.s_axi_rvalid  = r_rvalid;
  assign axi.s_axi_rresp   = r_rresp;
  assign axi.s_axi_rdata   = r_rdata;

  assign init_pulse  = r_init_pulse;
  assign loopback_en = r_loopback;
  assign miso_delay  = r_miso_delay;
  assign pkt_len     = r_pkt_len;

  // Protection bits and the byte offset within a word carry no meaning here.
  logic w_unused;
  assign w_unused = ^{axi.s_axi_awprot, axi.s_axi_arprot,
                      axi.s_axi_araddr[1:0], w_waddr[1:0]};

endmodule

// File: tb/tb_rhd_axil_regs.sv
module tb_rhd_axil_regs;

  logic        rhd_aclk = 1'b0;
  logic        rhd_areset;
  logic        core_busy;
  logic        overflow_evt;
  logic        init_pulse;
  logic        loopback_en;
  logic [31:0] miso_delay;
  logic [15:0] pkt_len;

  int checks = 0;
  int errors = 0;
  int init_cnt = 0;
  int b_rises = 0;
  logic bvalid_q = 1'b0;

  rhd_axil_regs_if #(.ADDR_WIDTH(5)) axi_if ();

  rhd_axil_regs #(.ADDR_WIDTH(5), .PKT_LEN_RST(16'd8)) dut (
    .rhd_aclk     (rhd_aclk),
    .rhd_areset   (rhd_areset),
    .axi          (axi_if),
    .init_pulse   (init_pulse),
    .loopback_en  (loopback_en),
    .miso_delay   (miso_delay),
    .pkt_len      (pkt_len),
    .core_busy    (core_busy),
    .overflow_evt (overflow_evt)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  always #5 rhd_aclk = ~rhd_aclk;

  // Cycle counters for init_pulse width and number of write responses.
  always @(negedge rhd_aclk) begin
    if (init_pulse === 1'b1) init_cnt++;
    if (axi_if.s_axi_bvalid === 1'b1 && bvalid_q !== 1'b1) b_rises++;
    bvalid_q = axi_if.s_axi_bvalid;
  end

  // ---------------------------------------------------------------------------
  // Comparison
  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (enter and leave 1 time unit after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int w_lead, input int hold, input bit ack,
                          output logic [1:0] resp);
    bit aw_done = 1'b0;
    bit w_done  = 1'b0;
    bit seen    = 1'b0;
    int n       = 0;
    int bad     = 0;
    axi_if.s_axi_wdata  = d;
    axi_if.s_axi_wstrb  = s;
    axi_if.s_axi_wvalid = 1'b1;
    if (w_lead == 0) begin
      axi_if.s_axi_awaddr  = a;
      axi_if.s_axi_awvalid = 1'b1;
    end
    while (!(aw_done && w_done) && n < 40) begin
      bit aw_hs;
      bit w_hs;
      @(negedge rhd_aclk);
      aw_hs = axi_if.s_axi_awvalid && axi_if.s_axi_awready;
      w_hs  = axi_if.s_axi_wvalid && axi_if.s_axi_wready;
      @(posedge rhd_aclk); #1;
      n++;
      if (aw_hs) begin axi_if.s_axi_awvalid = 1'b0; aw_done = 1'b1; end
      if (w_hs)  begin axi_if.s_axi_wvalid  = 1'b0; w_done  = 1'b1; end
      if (!aw_done && !axi_if.s_axi_awvalid && n >= w_lead) begin
        axi_if.s_axi_awaddr  = a;
        axi_if.s_axi_awvalid = 1'b1;
      end
    end
    axi_if.s_axi_awvalid = 1'b0;
    axi_if.s_axi_wvalid  = 1'b0;
    chk("wr_accept", 32'(aw_done && w_done), 32'd1);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge rhd_aclk);
      if (axi_if.s_axi_bvalid === 1'b1) seen = 1'b1;
      else begin @(posedge rhd_aclk); #1; end
    end
    chk("wr_resp_seen", 32'(seen), 32'd1);
    resp = axi_if.s_axi_bresp;
    for (int i = 0; i < hold; i++) begin
      @(negedge rhd_aclk);
      if (!(axi_if.s_axi_bvalid === 1'b1 && axi_if.s_axi_awready === 1'b0)) bad++;
    end
    if (hold > 0) chk("bvalid_hold", 32'(bad), 32'd0);
    if (ack) axi_if.s_axi_bready = 1'b1;
    @(posedge rhd_aclk); #1;
    axi_if.s_axi_bready = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] a, output logic [31:0] data, output logic [1:0] resp);
    bit done = 1'b0;
    bit seen = 1'b0;
    int n    = 0;
    axi_if.s_axi_araddr  = a;
    axi_if.s_axi_arvalid = 1'b1;
    while (!done && n < 40) begin
      @(negedge rhd_aclk);
      if (axi_if.s_axi_arready === 1'b1) done = 1'b1;
      @(posedge rhd_aclk); #1;
      n++;
    end
    axi_if.s_axi_arvalid = 1'b0;
    chk("rd_accept", 32'(done), 32'd1);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge rhd_aclk);
      if (axi_if.s_axi_rvalid === 1'b1) seen = 1'b1;
      else begin @(posedge rhd_aclk); #1; end
    end
    chk("rd_resp_seen", 32'(seen), 32'd1);
    data = axi_if.s_axi_rdata;
    resp = axi_if.s_axi_rresp;
    axi_if.s_axi_rready = 1'b1;
    @(posedge rhd_aclk); #1;
    axi_if.s_axi_rready = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] rd;
    logic [1:0]  rsp;
    int          br0;
    int          i0;

    rhd_areset           = 1'b1;
    core_busy            = 1'b0;
    overflow_evt         = 1'b0;
    axi_if.s_axi_awaddr  = '0;
    axi_if.s_axi_awprot  = '0;
    axi_if.s_axi_awvalid = 1'b0;
    axi_if.s_axi_wdata   = '0;
    axi_if.s_axi_wstrb   = '0;
    axi_if.s_axi_wvalid  = 1'b0;
    axi_if.s_axi_bready  = 1'b0;
    axi_if.s_axi_araddr  = '0;
    axi_if.s_axi_arprot  = '0;
    axi_if.s_axi_arvalid = 1'b0;
    axi_if.s_axi_rready  = 1'b0;

    // Reset values
    #1;
    chk("rst_awready", 32'(axi_if.s_axi_awready), 32'd0);
    chk("rst_wready",  32'(axi_if.s_axi_wready),  32'd0);
    chk("rst_arready", 32'(axi_if.s_axi_arready), 32'd0);
    chk("rst_bvalid",  32'(axi_if.s_axi_bvalid),  32'd0);
    chk("rst_rvalid",  32'(axi_if.s_axi_rvalid),  32'd0);
    chk("rst_rdata",   axi_if.s_axi_rdata,        32'd0);
    chk("rst_pkt_len", 32'(pkt_len),              32'd8);
    chk("rst_miso",    miso_delay,                32'd0);
    chk("rst_loop",    32'(loopback_en),          32'd0);
    chk("rst_init",    32'(init_pulse),           32'd0);

    repeat (3) @(posedge rhd_aclk);
    #1 rhd_areset = 1'b0;
    @(negedge rhd_aclk);
    chk("rdy_before_edge", 32'(axi_if.s_axi_awready), 32'd0);
    @(posedge rhd_aclk); #1;
    @(negedge rhd_aclk);
    chk("rdy_aw_after_edge", 32'(axi_if.s_axi_awready), 32'd1);
    chk("rdy_w_after_edge",  32'(axi_if.s_axi_wready),  32'd1);
    chk("rdy_ar_after_edge", 32'(axi_if.s_axi_arready), 32'd1);
    @(posedge rhd_aclk); #1;

    // MISO_DELAY, AW and W in the same cycle
    do_write(5'h04, 32'h2222_2222, 4'hF, 0, 0, 1'b1, rsp);
    chk("miso_bresp", 32'(rsp), 32'd0);
    chk("miso_out", miso_delay, 32'h2222_2222);
    do_read(5'h04, rd, rsp);
    chk("miso_rdata", rd, 32'h2222_2222);
    chk("miso_rresp", 32'(rsp), 32'd0);

    // CTRL, W three cycles ahead of AW
    i0  = init_cnt;
    br0 = b_rises;
    do_write(5'h00, 32'h0000_0021, 4'hF, 3, 0, 1'b1, rsp);
    repeat (3) @(posedge rhd_aclk); #1;
    chk("ctrl_bresp", 32'(rsp), 32'd0);
    chk("ctrl_one_resp", 32'(b_rises - br0), 32'd1);
    chk("ctrl_init_width", 32'(init_cnt - i0), 32'd1);
    chk("ctrl_loopback", 32'(loopback_en), 32'd1);
    do_read(5'h00, rd, rsp);
    chk("ctrl_rdata", rd, 32'h0000_0020);

    // PKT_LEN: zero clamps to 1, then byte-lane write
    do_write(5'h08, 32'h0000_0000, 4'hF, 0, 0, 1'b1, rsp);
    chk("pkt_zero_clamp", 32'(pkt_len), 32'h0000_0001);
    do_write(5'h08, 32'h1234_5678, 4'b0001, 0, 0, 1'b1, rsp);
    chk("pkt_lane0", 32'(pkt_len), 32'h0000_0078);
    do_read(5'h08, rd, rsp);
    chk("pkt_rdata", rd, 32'h0000_0078);

    // wstrb=0 commits nothing but answers
    do_write(5'h04, 32'hDEAD_BEEF, 4'b0000, 0, 0, 1'b1, rsp);
    chk("strb0_bresp", 32'(rsp), 32'd0);
    chk("strb0_miso", miso_delay, 32'h2222_2222);

    // STATUS: sticky overflow
    overflow_evt = 1'b1;
    @(posedge rhd_aclk); #1;
    overflow_evt = 1'b0;
    do_read(5'h0C, rd, rsp);
    chk("ovf_set", rd, 32'h0000_0002);

    // Clear on the same edge as a new event: set wins
    axi_if.s_axi_awaddr  = 5'h0C;
    axi_if.s_axi_awvalid = 1'b1;
    axi_if.s_axi_wdata   = 32'h0000_0002;
    axi_if.s_axi_wstrb   = 4'b0001;
    axi_if.s_axi_wvalid  = 1'b1;
    overflow_evt         = 1'b1;
    @(negedge rhd_aclk);
    chk("same_edge_ready", 32'(axi_if.s_axi_awready && axi_if.s_axi_wready), 32'd1);
    @(posedge rhd_aclk); #1;
    axi_if.s_axi_awvalid = 1'b0;
    axi_if.s_axi_wvalid  = 1'b0;
    overflow_evt         = 1'b0;
    @(negedge rhd_aclk);
    chk("same_edge_bvalid", 32'(axi_if.s_axi_bvalid), 32'd1);
    axi_if.s_axi_bready = 1'b1;
    @(posedge rhd_aclk); #1;
    axi_if.s_axi_bready = 1'b0;
    core_busy = 1'b1;
    do_read(5'h0C, rd, rsp);
    chk("ovf_set_wins", rd, 32'h0000_0003);

    do_write(5'h0C, 32'h0000_0002, 4'b0001, 0, 0, 1'b1, rsp);
    do_read(5'h0C, rd, rsp);
    chk("ovf_cleared", rd, 32'h0000_0001);
    core_busy = 1'b0;

    // Unmapped read and write; bready held low for 5 cycles
    do_read(5'h14, rd, rsp);
    chk("unmapped_rresp", 32'(rsp), 32'd2);
    chk("unmapped_rdata", rd, 32'd0);
    do_write(5'h18, 32'hFFFF_FFFF, 4'hF, 0, 5, 1'b1, rsp);
    chk("unmapped_bresp", 32'(rsp), 32'd2);
    do_read(5'h00, rd, rsp);
    chk("unmapped_ctrl_kept", rd, 32'h0000_0020);
    chk("unmapped_miso_kept", miso_delay, 32'h2222_2222);
    chk("unmapped_pkt_kept", 32'(pkt_len), 32'h0000_0078);

    // Reset with a pending response, a waiting write and a pending read
    do_write(5'h08, 32'h0000_0055, 4'hF, 0, 0, 1'b0, rsp);
    chk("pre_rst_pkt", 32'(pkt_len), 32'h0000_0055);
    axi_if.s_axi_awaddr  = 5'h08;
    axi_if.s_axi_awvalid = 1'b1;
    axi_if.s_axi_wdata   = 32'h0000_0099;
    axi_if.s_axi_wvalid  = 1'b1;
    axi_if.s_axi_araddr  = 5'h04;
    axi_if.s_axi_arvalid = 1'b1;
    @(negedge rhd_aclk);
    chk("pre_rst_awready", 32'(axi_if.s_axi_awready), 32'd0);
    chk("pre_rst_bvalid", 32'(axi_if.s_axi_bvalid), 32'd1);
    @(posedge rhd_aclk); #1;
    axi_if.s_axi_arvalid = 1'b0;
    @(negedge rhd_aclk);
    chk("pre_rst_rvalid", 32'(axi_if.s_axi_rvalid), 32'd1);
    #2 rhd_areset = 1'b1;
    #1;
    chk("arst_awready", 32'(axi_if.s_axi_awready), 32'd0);
    chk("arst_wready",  32'(axi_if.s_axi_wready),  32'd0);
    chk("arst_arready", 32'(axi_if.s_axi_arready), 32'd0);
    chk("arst_bvalid",  32'(axi_if.s_axi_bvalid),  32'd0);
    chk("arst_rvalid",  32'(axi_if.s_axi_rvalid),  32'd0);
    chk("arst_rdata",   axi_if.s_axi_rdata,        32'd0);
    chk("arst_pkt_len", 32'(pkt_len),              32'd8);
    chk("arst_miso",    miso_delay,                32'd0);
    chk("arst_loop",    32'(loopback_en),          32'd0);
    axi_if.s_axi_awvalid = 1'b0;
    axi_if.s_axi_wvalid  = 1'b0;
    br0 = b_rises;
    repeat (2) @(posedge rhd_aclk);
    #1 rhd_areset = 1'b0;
    repeat (6) @(negedge rhd_aclk);
    chk("post_rst_no_resp", 32'(b_rises - br0), 32'd0);
    chk("post_rst_bvalid", 32'(axi_if.s_axi_bvalid), 32'd0);
    chk("post_rst_pkt_len", 32'(pkt_len), 32'h0000_0008);
    @(posedge rhd_aclk); #1;
    do_read(5'h08, rd, rsp);
    chk("post_rst_pkt_rdata", rd, 32'h0000_0008);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
